// File: rtl/vxe_pipe_arb.sv
// Round-robin arbiter and flow controller sharing one external stall-able
// shift pipe between NREQ requesters. A valid bit and requester tag are
// tracked per pipe stage so each result is routed back to its issuer.
module vxe_pipe_arb #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int NSTAGES    = 3
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NREQ-1:0]            i_req_valid,
    output logic [NREQ-1:0]            o_req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] i_req_data,
    output logic [DATA_WIDTH-1:0]      o_pipe_in,
    output logic                       o_pipe_en,
    input  logic [DATA_WIDTH-1:0]      i_pipe_out,
    output logic [NREQ-1:0]            o_rsp_valid,
    input  logic [NREQ-1:0]            i_rsp_ready,
    output logic [DATA_WIDTH-1:0]      o_rsp_data
);

    localparam int TAG_W = (NREQ > 2) ? $clog2(NREQ) : 1;

    // Stage 0 is the pipe head; stage NSTAGES-1 is the tail being written.
    logic [NSTAGES-1:0] vld;
    logic [TAG_W-1:0]   tag [NSTAGES];
    logic [TAG_W-1:0]   ptr;

    logic               head_ready;
    logic               grant_found;
    logic [TAG_W-1:0]   grant;
    logic [TAG_W-1:0]   ptr_next;
    int                 idx;

    // Head routing: steer the head result to its owner and stall on backpressure.
    always_comb begin
        head_ready  = 1'b0;
        o_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag[0] == TAG_W'(i)) begin
                head_ready     = i_rsp_ready[i];
                o_rsp_valid[i] = nrst & vld[0];
            end
        end
        o_pipe_en = !(vld[0] && !head_ready);
    end

    assign o_rsp_data = i_pipe_out;

    // Round-robin search starting at ptr; the granted payload feeds the tail.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        o_req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && i_req_valid[idx]) begin
                grant_found      = 1'b1;
                grant            = TAG_W'(idx);
                o_req_ready[idx] = nrst & o_pipe_en;
            end
        end
        ptr_next  = TAG_W'((int'(grant) + 1) % NREQ);
        o_pipe_in = i_req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Tracking state shifts in lockstep with the pipe; stalled edges hold everything.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            vld <= '0;
            ptr <= '0;
            for (int s = 0; s < NSTAGES; s++) begin
                tag[s] <= '0;
            end
        end else if (o_pipe_en) begin
            for (int s = 0; s < NSTAGES - 1; s++) begin
                vld[s] <= vld[s+1];
                tag[s] <= tag[s+1];
            end
            vld[NSTAGES-1] <= grant_found;
            tag[NSTAGES-1] <= grant;
            if (grant_found) begin
                ptr <= ptr_next;
            end
        end
    end

endmodule
